// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX hazard sources in, pipeline control out.
// The slave modport is the hazard controller; master is the pipeline side.
// md_state mirrors the mul/div FSM state (0 = IDLE, 1 = MD_BUSY) for observation.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_uses_hilo;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             md_start;
    logic             jump_taken;
    logic             branch_taken;
    logic             stall;
    logic             flush_if;
    logic             flush_id;
    logic             md_busy;
    logic             md_state;
    logic [CNT_W-1:0] perf_stalls;
    logic [CNT_W-1:0] perf_flushes;

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_uses_hilo,
        input  ex_mem_read, ex_rd, md_start, jump_taken, branch_taken,
        output stall, flush_if, flush_id, md_busy, md_state,
        output perf_stalls, perf_flushes
    );

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_uses_hilo,
        output ex_mem_read, ex_rd, md_start, jump_taken, branch_taken,
        input  stall, flush_if, flush_id, md_busy, md_state,
        input  perf_stalls, perf_flushes
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard / flush controller for the 5-stage MIPS core.
// Produces stall, flush_if and flush_id combinationally from ID/EX hazard
// sources plus a registered mul/div busy counter.
// Optional macro HAZARD_PERF_CNT_EN enables the stall/flush performance
// counters; without it both counter outputs are tied to zero.
module hazard_ctrl #(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    hazard_ctrl_if.slave   bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [5:0] MD_LOAD = MD_LATENCY[5:0];

    md_state_t  state_q, state_d;
    logic [5:0] md_cnt_q, md_cnt_d;
    logic       load_use;
    logic       hilo_wait;
    logic       md_busy;

    // Mul/div state register and busy counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            md_cnt_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Next-state: md_start (re)loads the count, otherwise count down to IDLE.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.md_start) begin
                    md_cnt_d = MD_LOAD;
                    state_d  = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (bus.md_start) begin
                    md_cnt_d = MD_LOAD;
                    state_d  = MD_BUSY;
                end else begin
                    md_cnt_d = md_cnt_q - 6'd1;
                    state_d  = (md_cnt_q == 6'd1) ? IDLE : MD_BUSY;
                end
            end
            default: begin
                md_cnt_d = 6'd0;
                state_d  = IDLE;
            end
        endcase
    end

    assign md_busy      = (state_q == MD_BUSY);
    assign bus.md_busy  = md_busy;
    assign bus.md_state = state_q;

    // Hazard detection; register 0 is never a real dependency.
    always_comb begin
        load_use  = 1'b0;
        hilo_wait = 1'b0;
        if (bus.ex_mem_read && (bus.ex_rd != 5'd0)) begin
            load_use = (bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                       (bus.id_uses_rt && (bus.id_rt == bus.ex_rd));
        end
        hilo_wait = bus.id_uses_hilo && md_busy;
    end

    // Prioritised control: taken branch, then stalls, then jump.
    always_comb begin
        bus.stall    = 1'b0;
        bus.flush_if = 1'b0;
        bus.flush_id = 1'b0;
        if (bus.branch_taken) begin
            bus.flush_if = 1'b1;
            bus.flush_id = 1'b1;
        end else if (load_use || hilo_wait) begin
            bus.stall    = 1'b1;
            bus.flush_id = 1'b1;
        end else if (bus.jump_taken) begin
            bus.flush_if = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stalls_q;
    logic [CNT_W-1:0] perf_flushes_q;

    // Free-running stall-cycle and IF-flush counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stalls_q  <= '0;
            perf_flushes_q <= '0;
        end else begin
            if (bus.stall) begin
                perf_stalls_q <= perf_stalls_q + 1'b1;
            end
            if (bus.flush_if) begin
                perf_flushes_q <= perf_flushes_q + 1'b1;
            end
        end
    end

    assign bus.perf_stalls  = perf_stalls_q;
    assign bus.perf_flushes = perf_flushes_q;
`else
    assign bus.perf_stalls  = '0;
    assign bus.perf_flushes = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, all checked against a cycle-indexed reference model.
module tb_hazard_ctrl;

    localparam int unsigned LAT   = 4;
    localparam int unsigned CNT_W = 32;

    logic clk;
    logic rst_n;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(
        .MD_LATENCY (LAT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the cycle of the latest mul/div issue since reset.
    int          cyc          = 0;
    bit          md_valid     = 1'b0;
    int          md_start_cyc = 0;
    logic [31:0] exp_stalls   = '0;
    logic [31:0] exp_flushes  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.id_uses_rs   = 1'b0;
        bus.id_uses_rt   = 1'b0;
        bus.id_uses_hilo = 1'b0;
        bus.ex_mem_read  = 1'b0;
        bus.ex_rd        = 5'd0;
        bus.md_start     = 1'b0;
        bus.jump_taken   = 1'b0;
        bus.branch_taken = 1'b0;
    endtask

    task automatic drive_load_use();
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = 5'd5;
        bus.id_rs       = 5'd5;
        bus.id_uses_rs  = 1'b1;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
    task automatic run_cycle(input string tag);
        bit   busy, lu, hw;
        logic e_stall, e_fi, e_fid;
        @(negedge clk);
        busy = md_valid && (cyc > md_start_cyc) && (cyc <= md_start_cyc + int'(LAT));
        lu   = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
               ((bus.id_uses_rs && bus.id_rs == bus.ex_rd) ||
                (bus.id_uses_rt && bus.id_rt == bus.ex_rd));
        hw   = bus.id_uses_hilo && busy;
        e_stall = 1'b0; e_fi = 1'b0; e_fid = 1'b0;
        if (bus.branch_taken) begin
            e_fi = 1'b1; e_fid = 1'b1;
        end else if (lu || hw) begin
            e_stall = 1'b1; e_fid = 1'b1;
        end else if (bus.jump_taken) begin
            e_fi = 1'b1;
        end
        check({tag, ".stall"},    32'(bus.stall),    32'(e_stall));
        check({tag, ".flush_if"}, 32'(bus.flush_if), 32'(e_fi));
        check({tag, ".flush_id"}, 32'(bus.flush_id), 32'(e_fid));
        check({tag, ".md_busy"},  32'(bus.md_busy),  32'(busy));
`ifdef HAZARD_PERF_CNT_EN
        check({tag, ".perf_stalls"},  bus.perf_stalls,  exp_stalls);
        check({tag, ".perf_flushes"}, bus.perf_flushes, exp_flushes);
`else
        check({tag, ".perf_stalls"},  bus.perf_stalls,  32'd0);
        check({tag, ".perf_flushes"}, bus.perf_flushes, 32'd0);
`endif
        @(posedge clk);
        if (!rst_n) begin
            md_valid    = 1'b0;
            exp_stalls  = '0;
            exp_flushes = '0;
        end else begin
            if (bus.md_start) begin
                md_valid     = 1'b1;
                md_start_cyc = cyc;
            end
            if (e_stall) exp_stalls++;
            if (e_fi)    exp_flushes++;
        end
        cyc++;
        #1;
    endtask

    initial begin
        // Reset.
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycle("reset_state");

        // Load-use on rs, then the same pattern with register 0.
        drive_load_use();
        run_cycle("load_use");
        drive_idle();
        bus.ex_mem_read = 1'b1; bus.id_uses_rs = 1'b1;
        run_cycle("load_use_r0");
        drive_idle();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd9; bus.id_rt = 5'd9; bus.id_uses_rt = 1'b1;
        run_cycle("load_use_rt");

        // Mul/div wait: mfhi stalled for LAT cycles, released after.
        drive_idle();
        bus.md_start = 1'b1;
        run_cycle("md_issue");
        drive_idle();
        bus.id_uses_hilo = 1'b1;
        for (int i = 0; i < int'(LAT) + 2; i++) run_cycle("md_wait");

        // Branch wins over a load-use stall.
        drive_idle();
        drive_load_use();
        bus.branch_taken = 1'b1;
        run_cycle("branch_over_stall");

        // Jump held off by hilo stall, flushes once the stall drops.
        drive_idle();
        bus.md_start = 1'b1;
        run_cycle("jump_md_issue");
        drive_idle();
        bus.id_uses_hilo = 1'b1;
        bus.jump_taken   = 1'b1;
        for (int i = 0; i < int'(LAT) + 2; i++) run_cycle("jump_during_stall");

        // Reset while the counter reads 2.
        drive_idle();
        bus.md_start = 1'b1;
        run_cycle("rst_md_issue");
        drive_idle();
        run_cycle("rst_md_cnt4");
        run_cycle("rst_md_cnt3");
        rst_n = 1'b0;
        bus.id_uses_hilo = 1'b1;
        run_cycle("rst_mid_op");
        rst_n = 1'b1;
        run_cycle("after_rst");
        run_cycle("after_rst2");

        // Performance counters: 3 stall cycles and 2 jumps after a reset.
        drive_idle();
        rst_n = 1'b0;
        run_cycle("perf_rst");
        rst_n = 1'b1;
        drive_load_use();
        for (int i = 0; i < 3; i++) run_cycle("perf_stall");
        drive_idle();
        bus.jump_taken = 1'b1;
        for (int i = 0; i < 2; i++) run_cycle("perf_jump");
        drive_idle();
        run_cycle("perf_idle");
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stalls_total",  bus.perf_stalls,  32'd3);
        check("perf_flushes_total", bus.perf_flushes, 32'd2);
`else
        check("perf_stalls_total",  bus.perf_stalls,  32'd0);
        check("perf_flushes_total", bus.perf_flushes, 32'd0);
`endif

        // Randomized traffic with small register fields to provoke hits.
        for (int i = 0; i < 2000; i++) begin
            bus.id_rs        = 5'($urandom_range(0, 3));
            bus.id_rt        = 5'($urandom_range(0, 3));
            bus.id_uses_rs   = 1'($urandom_range(0, 1));
            bus.id_uses_rt   = 1'($urandom_range(0, 1));
            bus.id_uses_hilo = 1'($urandom_range(0, 1));
            bus.ex_mem_read  = 1'($urandom_range(0, 1));
            bus.ex_rd        = 5'($urandom_range(0, 3));
            bus.md_start     = ($urandom_range(0, 7) == 0);
            bus.jump_taken   = ($urandom_range(0, 5) == 0);
            bus.branch_taken = ($urandom_range(0, 7) == 0);
            rst_n            = ($urandom_range(0, 63) != 0);
            run_cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
